// File: rtl/rr_mux_n.sv
// Registered N-channel valid/ready multiplexer with round-robin or fixed-select
// arbitration feeding a single-entry output register.
module rr_mux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   fixed_sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  // Handshake: a word moves whenever valid and ready are both high at a rising
  // edge; in_ready only ever asserts for the single granted channel.
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             found;
  logic [SEL_W-1:0] gidx;
  logic             load;

  // In fixed mode at most one request bit survives, so the same search
  // yields grant == req; an out-of-range fixed_sel matches no channel.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = in_valid[i] && (!mode || (fixed_sel == SEL_W'(i)));
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = SEL_W'(idx);
      end
    end
    grant = found ? ({{(N-1){1'b0}}, 1'b1} << gidx) : '0;
  end

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      if (found) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[gidx*WIDTH +: WIDTH];
        out_sel_d   = gidx;
        if (!mode) ptr_d = gidx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Pointer resets to N-1 so that channel 0 wins the first round-robin search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SEL_W'(N-1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: directed scenarios plus randomized traffic against a
// priority-list reference model and an expected-word queue.
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT A: N=4, WIDTH=8
  logic        a_mode;
  logic [1:0]  a_fsel;
  logic [3:0]  a_iv;
  logic [31:0] a_id;
  logic [3:0]  a_ir;
  logic        a_ov;
  logic [7:0]  a_od;
  logic [1:0]  a_os;
  logic        a_ordy;

  // DUT B: N=3, WIDTH=8 (select field can address a missing channel)
  logic        b_mode;
  logic [1:0]  b_fsel;
  logic [2:0]  b_iv;
  logic [23:0] b_id;
  logic [2:0]  b_ir;
  logic        b_ov;
  logic [7:0]  b_od;
  logic [1:0]  b_os;
  logic        b_ordy;

  // DUT C: N=2, WIDTH=1 (2:1 mux equivalence)
  logic        c_mode;
  logic [0:0]  c_fsel;
  logic [1:0]  c_iv;
  logic [1:0]  c_id;
  logic [1:0]  c_ir;
  logic        c_ov;
  logic [0:0]  c_od;
  logic [0:0]  c_os;
  logic        c_ordy;

  rr_mux_n #(.WIDTH(8), .N(4)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .fixed_sel(a_fsel),
    .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_ordy)
  );

  rr_mux_n #(.WIDTH(8), .N(3)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .fixed_sel(b_fsel),
    .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(b_ordy)
  );

  rr_mux_n #(.WIDTH(1), .N(2)) u_c (
    .clk(clk), .rst_n(rst_n), .mode(c_mode), .fixed_sel(c_fsel),
    .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_sel(c_os), .out_ready(c_ordy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state for DUT A
  int          m_ptr;
  bit          m_ov;
  int          m_od;
  int          m_os;
  logic [31:0] exp_q[$];

  // Winner among valid channels, visiting them in priority order after m_ptr.
  function automatic int m_pick();
    int order[$];
    if (a_mode) return a_iv[a_fsel] ? int'(a_fsel) : -1;
    for (int k = 1; k <= 4; k++) order.push_back((m_ptr + k) % 4);
    foreach (order[j]) if (a_iv[order[j]]) return order[j];
    return -1;
  endfunction

  // Called just after an edge with inputs already driven; ends just after the next edge.
  task automatic a_cycle(output int acc);
    int         g;
    bit         ld;
    logic [31:0] w;
    #1;
    g  = m_pick();
    ld = !m_ov || a_ordy;
    check("in_ready", a_ir, (ld && g >= 0) ? (32'd1 << g) : 32'd0);
    if (m_ov && a_ordy) begin
      w = exp_q.pop_front();
      check("pop_data", a_od, w);
    end
    acc = -1;
    if (ld) begin
      if (g >= 0) begin
        m_ov = 1'b1;
        m_od = int'(a_id[g*8 +: 8]);
        m_os = g;
        if (!a_mode) m_ptr = g;
        exp_q.push_back(32'(m_od));
        acc = g;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", a_ov, m_ov);
    check("out_data", a_od, m_od);
    check("out_sel", a_os, m_os);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    a_iv   = 4'($urandom);
    a_id   = $urandom;
    a_mode = 1'($urandom);
    a_fsel = 2'($urandom);
    a_ordy = 1'($urandom);
    #1;
    check("rst_ov", a_ov, 0);
    check("rst_od", a_od, 0);
    check("rst_os", a_os, 0);
    check("rst_ir", a_ir, 0);
    @(posedge clk);
    #1;
    check("rst_ir_hold", a_ir, 0);
    check("rst_ov_hold", a_ov, 0);
    check("rst_b_ov", b_ov, 0);
    check("rst_c_ov", c_ov, 0);
    rst_n = 1'b1;
    m_ptr = 3;
    m_ov  = 1'b0;
    m_od  = 0;
    m_os  = 0;
    exp_q.delete();
  endtask

  task automatic all_valid();
    a_mode = 1'b0;
    a_fsel = 2'd0;
    a_iv   = 4'hF;
    a_id   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_ordy = 1'b1;
  endtask

  initial begin
    int acc;
    int rr_exp[6];
    int sp_exp[4];
    int b_exp[4];
    logic [1:0] av;

    b_mode = 0; b_fsel = 0; b_iv = 0; b_id = 0; b_ordy = 1;
    c_mode = 0; c_fsel = 0; c_iv = 0; c_id = 0; c_ordy = 1;
    a_mode = 0; a_fsel = 0; a_iv = 0; a_id = 0; a_ordy = 1;
    @(posedge clk);
    #1;

    // Round-robin sweep from reset
    do_reset();
    all_valid();
    rr_exp = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      a_cycle(acc);
      check("rr_sel", a_os, rr_exp[i]);
      check("rr_data", a_od, 32'hA0 + rr_exp[i]);
      check("rr_nobubble", a_ov, 1);
    end

    // Sparse requests, then a single requester
    do_reset();
    all_valid();
    a_iv = 4'b1010;
    sp_exp = '{1, 3, 1, 3};
    for (int i = 0; i < 4; i++) begin
      a_cycle(acc);
      check("sparse_sel", a_os, sp_exp[i]);
    end
    a_iv = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      a_cycle(acc);
      check("single_sel", a_os, 1);
    end

    // Backpressure, fixed select, return to round-robin
    do_reset();
    all_valid();
    a_cycle(acc);
    a_cycle(acc);
    a_ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_cycle(acc);
      check("bp_sel", a_os, 1);
      check("bp_data", a_od, 32'hA1);
      check("bp_ready", a_ir, 0);
    end
    a_ordy = 1'b1;
    a_cycle(acc);
    check("bp_resume", a_os, 2);
    a_mode = 1'b1;
    a_fsel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      a_cycle(acc);
      check("fix_sel", a_os, 2);
      check("fix_ready", a_ir, 4'b0100);
    end
    a_mode = 1'b0;
    a_cycle(acc);
    check("rr_resume", a_os, 3);

    // Out-of-range fixed select and wrap on a 3-channel instance
    b_mode = 1'b1; b_fsel = 2'd1; b_iv = 3'b111; b_ordy = 1'b1;
    b_id = {8'hB2, 8'hB1, 8'hB0};
    @(posedge clk);
    #1;
    check("b_fix_ov", b_ov, 1);
    check("b_fix_sel", b_os, 1);
    check("b_fix_data", b_od, 8'hB1);
    b_fsel = 2'd3;
    #1;
    check("b_oor_ready", b_ir, 0);
    @(posedge clk);
    #1;
    check("b_oor_ov", b_ov, 0);
    check("b_oor_sel_hold", b_os, 1);
    check("b_oor_data_hold", b_od, 8'hB1);
    b_mode = 1'b0;
    b_exp = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("b_rr_sel", b_os, b_exp[i]);
      check("b_rr_data", b_od, 8'hB0 + b_exp[i]);
    end
    b_iv = 3'b000;

    // 2:1 mux truth table
    c_mode = 1'b1; c_iv = 2'b11; c_ordy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        av     = 2'(a);
        c_fsel = 1'(s);
        c_id   = av;
        @(posedge clk);
        #1;
        check("mux2_data", c_od, av[s]);
        check("mux2_sel", c_os, s);
        check("mux2_ov", c_ov, 1);
      end
    end
    c_iv = 2'b00;

    // Randomized traffic with compliant producers, reset in the middle
    do_reset();
    a_mode = 1'b0;
    a_iv   = 4'b0;
    a_ordy = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        do_reset();
        a_ordy = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (!a_iv[i] && $urandom_range(0, 1) == 1) begin
          a_iv[i]        = 1'b1;
          a_id[i*8 +: 8] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 7) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 3) == 0) a_fsel = 2'($urandom);
      a_ordy = ($urandom_range(0, 3) != 0);
      a_cycle(acc);
      if (acc >= 0) a_iv[acc] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
